ahb_slave_data_phase: RTL and testbench

- AHB slave data-phase stage that sits directly downstream of the slave's address-mapping decoder.
- Registers each accepted address phase together with the decoder's write_select, read_select and hresp.
- In the following data phase it performs the register write or read, or drives the two-cycle AHB ERROR response.
- Owns the slave's register file: payload, data_size and a clear-on-read error status.

---
 rtl/ahb_slave_pkg.sv | 42 ++++
 rtl/ahb_byte_mask.sv | 19 +
 rtl/ahb_slave_data_phase.sv | 158 +++++++++++++++
 tb/tb_ahb_slave_data_phase.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_pkg.sv
// Shared encodings for the AHB slave data-phase stage.
// Bus codes, decoder select values, FSM states.
package ahb_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    WSEL_PAY_LO = 2'd0,
    WSEL_PAY_HI = 2'd1,
    WSEL_DSIZE  = 2'd2,
    WSEL_NONE   = 2'd3
  } wsel_e;

  typedef enum logic [1:0] {
    RSEL_ERR    = 2'd0,
    RSEL_PAY    = 2'd1,
    RSEL_PAY_HI = 2'd2,
    RSEL_DSIZE  = 2'd3
  } rsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_byte_mask.sv
// Converts an AHB transfer size into a low-lane write mask.
// Sizes above a word saturate to the full 32-bit mask.
module ahb_byte_mask
  import ahb_slave_pkg::*;
(
  input  logic [2:0]  hsize_i,
  output logic [31:0] mask_o
);

  always_comb begin
    mask_o = 32'hFFFF_FFFF;
    unique case (1'b1)
      (hsize_i == HSIZE_BYTE): mask_o = 32'h0000_00FF;
      (hsize_i == HSIZE_HALF): mask_o = 32'h0000_FFFF;
      default:                 mask_o = 32'hFFFF_FFFF;
    endcase
  end

endmodule

// File: rtl/ahb_slave_data_phase.sv
// AHB slave data-phase stage: registers address phases and
// performs register access or the two-cycle ERROR response.
module ahb_slave_data_phase
  import ahb_slave_pkg::*;
#(
  parameter int PAYLOAD_W   = 32,
  parameter int DATA_SIZE_W = 16,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel_x,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic                   hready,
  input  logic [31:0]            hwdata,
  input  logic [1:0]             map_write_select,
  input  logic [1:0]             map_read_select,
  input  logic                   map_hresp,
  output logic [31:0]            hrdata,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [PAYLOAD_W-1:0]   payload,
  output logic [DATA_SIZE_W-1:0] data_size,
  output logic                   commit
);

  state_e                 state_q;
  logic                   hready_q;
  logic                   hresp_q;
  logic                   hwrite_q;
  logic [2:0]             hsize_q;
  wsel_e                  wsel_q;
  rsel_e                  rsel_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic [DATA_SIZE_W-1:0] dsize_q;
  logic                   commit_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic                   err_sticky_q;
  logic [31:0]            mask;

  logic trans_ok;
  logic accept;
  logic err_entry;
  logic do_wr;
  logic do_clr;

  assign trans_ok = (htrans == HTRANS_NONSEQ)
                 || (htrans == HTRANS_SEQ);
  // ERR1 holds the bus, so no address phase can land there
  assign accept = (state_q != ST_ERR1)
               && hsel_x && hready && trans_ok;
  assign err_entry = accept && map_hresp;
  assign do_wr  = (state_q == ST_DATA) && hwrite_q;
  assign do_clr = (state_q == ST_DATA) && !hwrite_q
               && (rsel_q == RSEL_ERR);

  ahb_byte_mask u_mask (
    .hsize_i (hsize_q),
    .mask_o  (mask)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_BYTE;
      wsel_q   <= WSEL_PAY_LO;
      rsel_q   <= RSEL_ERR;
    end else if (state_q == ST_ERR1) begin
      state_q  <= ST_ERR2;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_ERROR;
    end else if (accept) begin
      hwrite_q <= hwrite;
      hsize_q  <= hsize;
      wsel_q   <= wsel_e'(map_write_select);
      rsel_q   <= rsel_e'(map_read_select);
      if (map_hresp) begin
        state_q  <= ST_ERR1;
        hready_q <= 1'b0;
        hresp_q  <= HRESP_ERROR;
      end else begin
        state_q  <= ST_DATA;
        hready_q <= 1'b1;
        hresp_q  <= HRESP_OKAY;
      end
    end else begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      payload_q    <= '0;
      dsize_q      <= '0;
      commit_q     <= 1'b0;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      commit_q <= do_wr && (wsel_q == WSEL_DSIZE);
      if (do_wr) begin
        unique case (wsel_q)
          WSEL_PAY_LO:
            payload_q <= (payload_q & ~mask)
                       | (hwdata & mask);
          WSEL_PAY_HI:
            payload_q[31:16] <=
              (payload_q[31:16] & ~mask[15:0])
              | (hwdata[15:0] & mask[15:0]);
          WSEL_DSIZE:
            dsize_q <=
              (dsize_q & ~mask[DATA_SIZE_W-1:0])
              | (hwdata[DATA_SIZE_W-1:0]
                 & mask[DATA_SIZE_W-1:0]);
          default: ;
        endcase
      end
      // a clear racing a new error keeps that error counted
      if (err_entry && do_clr) begin
        err_count_q  <= ERR_CNT_W'(1);
        err_sticky_q <= 1'b1;
      end else if (err_entry) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != '1)
          err_count_q <= err_count_q + ERR_CNT_W'(1);
      end else if (do_clr) begin
        err_count_q  <= '0;
        err_sticky_q <= 1'b0;
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if ((state_q == ST_DATA) && !hwrite_q) begin
      unique case (rsel_q)
        RSEL_ERR:
          hrdata = 32'({err_count_q, err_sticky_q});
        RSEL_PAY:    hrdata = payload_q;
        RSEL_PAY_HI: hrdata = {16'h0, payload_q[31:16]};
        default:     hrdata = 32'(dsize_q);
      endcase
    end
  end

  assign hreadyout = hready_q;
  assign hresp     = hresp_q;
  assign payload   = payload_q;
  assign data_size = dsize_q;
  assign commit    = commit_q;

endmodule

// File: tb/tb_ahb_slave_data_phase.sv
// Directed bench for ahb_slave_data_phase.
// Inputs change 1ns after the rising edge; outputs are sampled there.
module tb_ahb_slave_data_phase;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel_x = 1'b0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic        hready = 1'b1;
  logic [31:0] hwdata = 32'h0;
  logic [1:0]  mws = 2'd0;
  logic [1:0]  mrs = 2'd0;
  logic        map_hresp = 1'b0;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] payload;
  logic [15:0] data_size;
  logic        commit;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_slave_data_phase #(
    .PAYLOAD_W   (32),
    .DATA_SIZE_W (16),
    .ERR_CNT_W   (8)
  ) dut (
    .hclk             (hclk),
    .hresetn          (hresetn),
    .hsel_x           (hsel_x),
    .htrans           (htrans),
    .hwrite           (hwrite),
    .hsize            (hsize),
    .hready           (hready),
    .hwdata           (hwdata),
    .map_write_select (mws),
    .map_read_select  (mrs),
    .map_hresp        (map_hresp),
    .hrdata           (hrdata),
    .hreadyout        (hreadyout),
    .hresp            (hresp),
    .payload          (payload),
    .data_size        (data_size),
    .commit           (commit)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic addr(input logic [1:0] t,
                      input logic w,
                      input logic [2:0] sz,
                      input logic [1:0] ws,
                      input logic [1:0] rs,
                      input logic e);
    hsel_x = 1'b1;
    htrans = t;
    hwrite = w;
    hsize = sz;
    mws = ws;
    mrs = rs;
    map_hresp = e;
  endtask

  task automatic idle();
    hsel_x = 1'b0;
    htrans = T_IDLE;
    hwrite = 1'b0;
    map_hresp = 1'b0;
  endtask

  task automatic do_error();
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b1);
    step();
    idle();
    step();
    step();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_payload", payload, 0);
    chk("rst_data_size", data_size, 0);
    chk("rst_commit", commit, 0);
    hresetn = 1'b1;
    step();

    addr(T_NSEQ, 1'b1, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("wr_word_ready", hreadyout, 1);
    hwdata = 32'hDEAD_BEEF;
    addr(T_SEQ, 1'b0, 3'd2, 2'd0, 2'd1, 1'b0);
    step();
    chk("wr_word_payload", payload, 32'hDEAD_BEEF);
    chk("rd_pay_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("rd_pay_ready", hreadyout, 1);
    addr(T_NSEQ, 1'b1, 3'd1, 2'd1, 2'd0, 1'b0);
    step();
    hwdata = 32'hFFFF_1234;
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd2, 1'b0);
    step();
    chk("wr_half_hi", payload, 32'h1234_BEEF);
    chk("rd_pay_hi", hrdata, 32'h0000_1234);
    addr(T_NSEQ, 1'b1, 3'd0, 2'd1, 2'd0, 1'b0);
    step();
    hwdata = 32'hAAAA_AA56;
    idle();
    step();
    chk("wr_byte_hi", payload, 32'h1256_BEEF);
    chk("idle_hrdata", hrdata, 0);

    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b1);
    step();
    idle();
    chk("err1_ready", hreadyout, 0);
    chk("err1_resp", hresp, 1);
    step();
    chk("err2_ready", hreadyout, 1);
    chk("err2_resp", hresp, 1);
    step();
    chk("err_idle_ready", hreadyout, 1);
    chk("err_idle_resp", hresp, 0);
    do_error();
    do_error();
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("status_3err", hrdata, 32'h7);
    step();
    chk("status_cleared", hrdata, 0);
    idle();
    step();

    do_error();
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("status_1err", hrdata, 32'h3);
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b1);
    step();
    idle();
    chk("clr_err_ready", hreadyout, 0);
    step();
    step();
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("clr_race_count", hrdata, 32'h3);
    idle();
    step();

    for (int i = 0; i < 300; i++) do_error();
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("err_saturate", hrdata, 32'h1FF);
    idle();
    step();

    addr(T_NSEQ, 1'b1, 3'd0, 2'd2, 2'd0, 1'b0);
    step();
    hwdata = 32'h1234_56A5;
    idle();
    chk("commit_early", commit, 0);
    step();
    chk("dsize_byte", data_size, 16'h00A5);
    chk("commit_pulse", commit, 1);
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd3, 1'b0);
    step();
    chk("commit_end", commit, 0);
    chk("rd_dsize", hrdata, 32'h0000_00A5);

    hwdata = 32'hFFFF_FFFF;
    addr(T_BUSY, 1'b1, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("busy_hrdata", hrdata, 0);
    addr(T_IDLE, 1'b1, 3'd2, 2'd2, 2'd0, 1'b0);
    step();
    step();
    chk("noacc_payload", payload, 32'h1256_BEEF);
    chk("noacc_dsize", data_size, 16'h00A5);
    chk("noacc_commit", commit, 0);

    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b1);
    step();
    idle();
    chk("pre_rst_ready", hreadyout, 0);
    hresetn = 1'b0;
    #1;
    chk("mid_rst_ready", hreadyout, 1);
    chk("mid_rst_resp", hresp, 0);
    chk("mid_rst_payload", payload, 0);
    chk("mid_rst_dsize", data_size, 0);
    #1;
    hresetn = 1'b1;
    addr(T_NSEQ, 1'b0, 3'd2, 2'd0, 2'd0, 1'b0);
    step();
    chk("post_rst_status", hrdata, 0);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
